// File: rtl/jtag_tap_core.sv
// jtag_tap_core: JTAG TAP controller with IR, BYPASS/IDCODE/USER data
// registers and the TDI/TDO serial path, clocked on tck.
//
// state  | meaning
// -------+------------------------------------------------
// TLR  F | test-logic-reset, ir forced to IDCODE
// RTI  C | run-test/idle
// SEL_DR 7 | select DR scan
// CAP_DR 6 | selected DR loads its capture value
// SH_DR  2 | selected DR shifts right, tdi into MSB
// EX1_DR 1 | exit1 DR
// PA_DR  3 | pause DR, shift contents held
// EX2_DR 0 | exit2 DR
// UPD_DR 5 | USER DR copied to user_dout when selected
// SEL_IR 4 | select IR scan
// CAP_IR E | ir_sr loads ...01
// SH_IR  A | ir_sr shifts right, tdi into MSB
// EX1_IR 9 | exit1 IR
// PA_IR  B | pause IR
// EX2_IR 8 | exit2 IR
// UPD_IR D | ir loads ir_sr
module jtag_tap_core #(
   parameter int                  IR_WIDTH    = 4,
   parameter int                  DR_WIDTH    = 16,
   parameter logic [31:0]         IDCODE_VAL  = 32'h1FC0_0A53,
   parameter logic [IR_WIDTH-1:0] IDCODE_INSN = IR_WIDTH'(4'h1),
   parameter logic [IR_WIDTH-1:0] USER_INSN   = IR_WIDTH'(4'h8)
) (
   input  logic                tck,
   input  logic                por,
   input  logic                tms,
   input  logic                tdi,
   output logic                tdo,
   output logic                tdo_en,
   output logic [3:0]          state,
   output logic [IR_WIDTH-1:0] ir,
   input  logic [DR_WIDTH-1:0] user_din,
   output logic [DR_WIDTH-1:0] user_dout,
   output logic                user_capture,
   output logic                user_update,
   output logic                sel_user
);

   typedef enum logic [3:0] {
      TLR    = 4'hF, RTI    = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6,
      SH_DR  = 4'h2, EX1_DR = 4'h1, PA_DR  = 4'h3, EX2_DR = 4'h0,
      UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA,
      EX1_IR = 4'h9, PA_IR  = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
   } tap_state_e;

   tap_state_e          state_q, state_d;
   logic [IR_WIDTH-1:0] ir_q, ir_sr_q, ir_sr_shift;
   logic                bypass_q;
   logic [31:0]         id_sr_q;
   logic [DR_WIDTH-1:0] user_sr_q, user_sr_shift, user_dout_q;
   logic                user_capture_q, user_update_q;
   logic                sel_user_w, sel_idcode_w;

   assign sel_user_w    = (ir_q == USER_INSN);
   assign sel_idcode_w  = (ir_q == IDCODE_INSN);
   // Written as shift-and-or so one-bit USER registers need no special case.
   assign ir_sr_shift   = (ir_sr_q >> 1) | (IR_WIDTH'(tdi) << (IR_WIDTH - 1));
   assign user_sr_shift = (user_sr_q >> 1) | (DR_WIDTH'(tdi) << (DR_WIDTH - 1));

   assign state        = state_q;
   assign ir           = ir_q;
   assign sel_user     = sel_user_w;
   assign user_dout    = user_dout_q;
   assign user_capture = user_capture_q;
   assign user_update  = user_update_q;
   assign tdo_en       = (state_q == SH_IR) || (state_q == SH_DR);

   // IEEE 1149.1 TMS-driven next-state function
   always_comb begin
      state_d = state_q;
      case (state_q)
         TLR:    state_d = tms ? TLR    : RTI;
         RTI:    state_d = tms ? SEL_DR : RTI;
         SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
         CAP_DR: state_d = tms ? EX1_DR : SH_DR;
         SH_DR:  state_d = tms ? EX1_DR : SH_DR;
         EX1_DR: state_d = tms ? UPD_DR : PA_DR;
         PA_DR:  state_d = tms ? EX2_DR : PA_DR;
         EX2_DR: state_d = tms ? UPD_DR : SH_DR;
         UPD_DR: state_d = tms ? SEL_DR : RTI;
         SEL_IR: state_d = tms ? TLR    : CAP_IR;
         CAP_IR: state_d = tms ? EX1_IR : SH_IR;
         SH_IR:  state_d = tms ? EX1_IR : SH_IR;
         EX1_IR: state_d = tms ? UPD_IR : PA_IR;
         PA_IR:  state_d = tms ? EX2_IR : PA_IR;
         EX2_IR: state_d = tms ? UPD_IR : SH_IR;
         UPD_IR: state_d = tms ? SEL_DR : RTI;
         default: state_d = TLR;
      endcase
   end

   // Serial output mux: LSB of whichever register is being shifted
   always_comb begin
      tdo = 1'b0;
      if (state_q == SH_IR) begin
         tdo = ir_sr_q[0];
      end else if (state_q == SH_DR) begin
         if (sel_user_w)        tdo = user_sr_q[0];
         else if (sel_idcode_w) tdo = id_sr_q[0];
         else                   tdo = bypass_q;
      end
   end

   // State register plus the registered USER capture/update pulses
   always_ff @(posedge tck) begin
      if (por) begin
         state_q        <= TLR;
         user_capture_q <= 1'b0;
         user_update_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         user_capture_q <= (state_q == CAP_DR) && sel_user_w;
         user_update_q  <= (state_q == UPD_DR) && sel_user_w;
      end
   end

   // Instruction and data registers: capture, shift, update
   always_ff @(posedge tck) begin
      if (por) begin
         ir_q        <= IDCODE_INSN;
         ir_sr_q     <= '0;
         bypass_q    <= 1'b0;
         id_sr_q     <= '0;
         user_sr_q   <= '0;
         user_dout_q <= '0;
      end else begin
         case (state_q)
            TLR:    ir_q    <= IDCODE_INSN;
            CAP_IR: ir_sr_q <= IR_WIDTH'(2'b01);
            SH_IR:  ir_sr_q <= ir_sr_shift;
            UPD_IR: ir_q    <= ir_sr_q;
            CAP_DR: begin
               if (sel_user_w)        user_sr_q <= user_din;
               else if (sel_idcode_w) id_sr_q   <= IDCODE_VAL;
               else                   bypass_q  <= 1'b0;
            end
            SH_DR: begin
               if (sel_user_w)        user_sr_q <= user_sr_shift;
               else if (sel_idcode_w) id_sr_q   <= {tdi, id_sr_q[31:1]};
               else                   bypass_q  <= tdi;
            end
            UPD_DR: if (sel_user_w) user_dout_q <= user_sr_q;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_tap_core.sv
// Directed bench for jtag_tap_core with hand-computed expected values.
module tb_jtag_tap_core;

   logic        tck = 1'b0;
   logic        por = 1'b1;
   logic        tms = 1'b0;
   logic        tdi = 1'b0;
   logic        tdo, tdo_en, user_capture, user_update, sel_user;
   logic [3:0]  state, ir;
   logic [15:0] user_din = '0;
   logic [15:0] user_dout;

   int n_assert = 0;
   int n_fail   = 0;

   jtag_tap_core dut (
      .tck(tck), .por(por), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
      .state(state), .ir(ir), .user_din(user_din), .user_dout(user_dout),
      .user_capture(user_capture), .user_update(user_update), .sel_user(sel_user)
   );

   always #5 tck = ~tck;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic tms_v);
      tms = tms_v;
      @(posedge tck);
      #1;
   endtask

   // Shift n bits LSB-first, leaving SH on the last bit; tdo sampled before each edge.
   task automatic scan(input int n, input logic [31:0] din, output logic [31:0] dout);
      dout = '0;
      for (int k = 0; k < n; k++) begin
         tms     = (k == n - 1);
         tdi     = din[k];
         dout[k] = tdo;
         @(posedge tck);
         #1;
      end
      tdi = 1'b0;
   endtask

   task automatic set_ir(input logic [3:0] val);
      logic [31:0] dummy;
      step(1); step(1); step(0); step(0);
      scan(4, {28'h0, val}, dummy);
      step(1); step(0);
   endtask

   // tms sequence from RTI visiting all 16 states, with expected codes.
   logic        walk_tms [20] = '{1,0,0,1,0,1,1,1,1,0,0,1,0,1,1,1,1,1,0,0};
   logic [3:0]  walk_st  [20] = '{4'h7,4'h6,4'h2,4'h1,4'h3,4'h0,4'h5,4'h7,4'h4,4'hE,
                                  4'hA,4'h9,4'hB,4'h8,4'hD,4'h7,4'h4,4'hF,4'hC,4'hC};
   logic [3:0]  five_st  [5]  = '{4'h1,4'h5,4'h7,4'h4,4'hF};

   initial begin
      logic [31:0] d;
      logic [3:0]  irtdo;

      // Reset
      por = 1'b1; step(0); step(0);
      check("rst_state", 32'(state), 32'hF);
      check("rst_ir", 32'(ir), 32'h1);
      check("rst_dout", 32'(user_dout), 32'h0);
      check("rst_tdo_en", 32'(tdo_en), 32'h0);
      check("rst_pulses", {30'h0, user_capture, user_update}, 32'h0);
      por = 1'b0; step(0);
      check("rst_to_rti", 32'(state), 32'hC);

      // Full state walk
      for (int i = 0; i < 20; i++) begin
         step(walk_tms[i]);
         check($sformatf("walk_%0d", i), 32'(state), 32'(walk_st[i]));
      end

      // Five ones from SH_DR
      step(1); step(0); step(0);
      check("to_sh_dr", 32'(state), 32'h2);
      for (int i = 0; i < 5; i++) begin
         step(1);
         check($sformatf("five_%0d", i), 32'(state), 32'(five_st[i]));
      end

      // IR scan of 4'h8 with a pause in the middle
      step(0); step(1); step(1); step(0); step(0);
      check("sh_ir", 32'(state), 32'hA);
      check("sh_ir_tdo_en", 32'(tdo_en), 32'h1);
      tms = 0; tdi = 0; irtdo[0] = tdo; step(0);
      tms = 1; tdi = 0; irtdo[1] = tdo; step(1);
      step(0);
      check("pa_ir", 32'(state), 32'hB);
      check("pa_ir_tdo_en", 32'(tdo_en), 32'h0);
      step(0); step(1); step(0);
      check("resume_sh_ir", 32'(state), 32'hA);
      tms = 0; tdi = 0; irtdo[2] = tdo; step(0);
      tms = 1; tdi = 1; irtdo[3] = tdo; step(1);
      tdi = 0;
      check("ir_tdo", 32'(irtdo), 32'h1);
      step(1);
      check("ir_hold_in_upd", 32'(ir), 32'h1);
      step(0);
      check("ir_user", 32'(ir), 32'h8);
      check("sel_user_1", 32'(sel_user), 32'h1);

      // IDCODE after reset
      por = 1; step(0); por = 0; step(0);
      check("id_ir", 32'(ir), 32'h1);
      check("sel_user_0", 32'(sel_user), 32'h0);
      step(1); step(0); step(0);
      scan(32, 32'h0, d);
      check("idcode", d, 32'h1FC0_0A53);
      step(1); step(0);
      check("id_no_update", 32'(user_update), 32'h0);

      // BYPASS with all-ones and with an unassigned opcode
      set_ir(4'hF);
      check("ir_F", 32'(ir), 32'hF);
      step(1); step(0); step(0);
      scan(4, 32'hD, d);
      check("bypass_F", d, 32'hA);
      step(1); step(0);
      set_ir(4'h5);
      check("ir_5", 32'(ir), 32'h5);
      step(1); step(0); step(0);
      scan(4, 32'hD, d);
      check("bypass_5", d, 32'hA);
      step(1); step(0);
      check("bypass_dout", 32'(user_dout), 32'h0);

      // USER scan
      user_din = 16'h3C5A;
      set_ir(4'h8);
      step(1); step(0);
      check("cap_dr", 32'(state), 32'h6);
      check("cap_pre", 32'(user_capture), 32'h0);
      step(0);
      check("cap_pulse", 32'(user_capture), 32'h1);
      scan(16, 32'hA5C3, d);
      check("user_tdo", d, 32'h3C5A);
      check("cap_once", 32'(user_capture), 32'h0);
      step(1);
      check("upd_dr", 32'(state), 32'h5);
      check("upd_pre", 32'(user_update), 32'h0);
      check("dout_pre", 32'(user_dout), 32'h0);
      step(0);
      check("upd_pulse", 32'(user_update), 32'h1);
      check("dout_new", 32'(user_dout), 32'hA5C3);
      check("no_cap_with_upd", 32'(user_capture), 32'h0);
      step(0);
      check("upd_once", 32'(user_update), 32'h0);
      check("dout_hold", 32'(user_dout), 32'hA5C3);

      // Repeat scan aborted by por mid-shift
      step(1); step(0); step(0);
      tdi = 1;
      for (int i = 0; i < 5; i++) step(0);
      por = 1; step(0);
      check("por_state", 32'(state), 32'hF);
      check("por_dout", 32'(user_dout), 32'h0);
      check("por_upd", 32'(user_update), 32'h0);
      check("por_ir", 32'(ir), 32'h1);
      por = 0; tdi = 0; step(1);
      check("post_por_state", 32'(state), 32'hF);
      check("post_por_upd", 32'(user_update), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/jtag_tap_core.md
Name: jtag_tap_core

Overview:
Full JTAG TAP built around the 16-state TMS controller. It adds a parametrised instruction register, BYPASS/IDCODE/USER data registers and the TDI/TDO serial path. The USER register gives the FIR core a DR_WIDTH-bit parallel capture/update port for coefficient and debug access. It is a single-clock block on tck.

Parameters:
IR_WIDTH, 4, instruction register width (>=2)
DR_WIDTH, 16, USER data register width (>=1)
IDCODE_VAL, 32'h1FC0_0A53, value captured by IDCODE DR (bit0 must be 1)
IDCODE_INSN, 4'h1, IDCODE opcode (IR_WIDTH bits)
USER_INSN, 4'h8, USER opcode (IR_WIDTH bits)

Ports:
tck  in  1  TAP clock; every register updates on the rising edge
por  in  1  synchronous, active-high reset
tms  in  1  test mode select
tdi  in  1  serial data in
tdo  out  1  serial data out
tdo_en  out  1  tdo valid/drive enable
state  out  4  current TAP state
ir  out  IR_WIDTH  active instruction
user_din  in  DR_WIDTH  parallel value captured into the USER DR
user_dout  out  DR_WIDTH  parallel value written by UPDATE_DR
user_capture  out  1  one-cycle pulse, USER capture happened
user_update  out  1  one-cycle pulse, user_dout written
sel_user  out  1  ir == USER_INSN

Behaviour:
- State encoding: TLR F, RTI C, SEL_DR 7, CAP_DR 6, SH_DR 2, EX1_DR 1, PA_DR 3, EX2_DR 0, UPD_DR 5, SEL_IR 4, CAP_IR E, SH_IR A, EX1_IR 9, PA_IR B, EX2_IR 8, UPD_IR D.
- Transitions follow IEEE 1149.1 exactly. Five consecutive tms=1 reach TLR from any state.
- por=1 at a rising edge puts the block into this state, regardless of current state (mid-shift included):
  - state=F, ir=IDCODE_INSN
  - all shift registers 0, user_dout 0
  - user_capture and user_update 0
- In TLR, ir is forced to IDCODE_INSN every cycle.
- IR path:
  - CAP_IR: ir_sr <= {0..0,2'b01}.
  - SH_IR: ir_sr shifts right, tdi enters the MSB.
  - UPD_IR: ir <= ir_sr. The new instruction is visible the cycle after UPD_IR.
  - ir does not change anywhere outside UPD_IR and TLR.
- DR select decode:
  - ir==IDCODE_INSN selects the 32-bit IDCODE register.
  - ir==USER_INSN selects the DR_WIDTH USER register.
  - All other opcodes, including all-ones, select the 1-bit BYPASS register.
- CAP_DR: the selected register loads its capture value.
  - BYPASS loads 0.
  - IDCODE loads IDCODE_VAL.
  - USER loads user_din; user_capture=1 on the following cycle.
- SH_DR: the selected register shifts right, tdi enters the MSB. Unselected registers hold.
- UPD_DR with USER selected: user_dout <= user_sr and user_update=1, both on the following cycle. With other instructions, user_dout holds and no pulse occurs.
- Pause states (PA_DR, PA_IR), EXIT states and RTI hold all shift register contents.
- tdo and tdo_en (combinational from registers):
  - tdo_en=1 iff state is SH_IR or SH_DR.
  - tdo = LSB of ir_sr in SH_IR, LSB of the selected DR in SH_DR, otherwise 0.
- Shift length: an N-bit register needs N SH cycles. The last bit is shifted on the transition out of SH (tms=1). TDO bit k is visible during shift cycle k.
- sel_user is combinational from ir.
- user_capture and user_update are never asserted together. Each is exactly one cycle wide.

Test Plan:
- Reset: por=1 for 2 cycles, then tms=0 for 1 cycle → state F then C, ir=4'h1, user_dout=0, tdo_en=0.
- TMS walk: from SH_DR (2), tms=1 x5 → states 1,5,7,4,F. A fixed tms sequence visits all 16 codes in IEEE order; compare against the golden table.
- IR scan, shifting 4'h8 LSB-first → tdo sequence 1,0,0,0 (the captured 01 pattern). After UPD_IR, ir=8 and sel_user=1. Pause/exit2 mid-scan resumes without losing bits.
- IDCODE after reset: DR scan of 32 bits with tdi=0 → tdo bits form 32'h1FC0_0A53 LSB-first.
- BYPASS: ir=4'hF, shift tdi=1,0,1,1 → tdo=0,1,0,1 (one-cycle delay). Opcode 4'h5 behaves identically.
- USER: user_din=16'h3C5A, ir=8, DR scan shifting 16'hA5C3.
  - tdo returns 16'h3C5A.
  - user_capture pulses once after CAP_DR.
  - After UPD_DR, user_dout=16'hA5C3 with a 1-cycle user_update pulse.
  - A repeat scan with por=1 asserted mid-shift → state F, user_dout=0, no update pulse.
